// File: rtl/ctrl_cell_mc.sv
// Multi-channel control cell: decodes instruction words into a TDM tile opcode/address
// stream and per-channel viewer mode/offset/address, with stall, flush and NOP bubbles.
module ctrl_cell_mc #(
   parameter int BLOCK_BITS  = 3,
   parameter int ADDR_BITS   = 6,
   parameter int TOC_WIDTH   = 4,
   parameter int MODE_BITS   = 2,
   parameter int NUM_CH      = 2,
   parameter int TILE_SLOTS  = 3,
   parameter int VIEW_SLOTS  = 2,
   parameter int ADDR_SRC_CH = NUM_CH - 1,
   parameter logic [TOC_WIDTH-1:0] WRITE_OP = 4'b1000,
   parameter logic [TOC_WIDTH-1:0] NOP_OP   = 4'b0000,
   localparam int BC   = (BLOCK_BITS + 1) * 2,
   localparam int CH_W = MODE_BITS + ADDR_BITS + BC,
   localparam int TS_W = (TILE_SLOTS > 1) ? $clog2(TILE_SLOTS) : 1,
   localparam int VS_W = (VIEW_SLOTS > 1) ? $clog2(VIEW_SLOTS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [TOC_WIDTH+NUM_CH*CH_W-1:0] code_in,
   output logic [TOC_WIDTH-1:0]          code_out,
   output logic [ADDR_BITS-1:0]          addr_i,
   output logic [TS_W-1:0]               tile_slot,
   output logic                          frame_start,
   output logic                          write,
   output logic [NUM_CH*MODE_BITS-1:0]   mode,
   output logic [NUM_CH*BC-1:0]          offset,
   output logic [NUM_CH*ADDR_BITS-1:0]   addr
);

   logic [TOC_WIDTH-1:0] op_q   [TILE_SLOTS];
   logic [TOC_WIDTH-1:0] op_d   [TILE_SLOTS];
   logic [ADDR_BITS-1:0] ta_q   [TILE_SLOTS];
   logic [ADDR_BITS-1:0] ta_d   [TILE_SLOTS];
   logic [MODE_BITS-1:0] vm_q   [VIEW_SLOTS][NUM_CH];
   logic [MODE_BITS-1:0] vm_d   [VIEW_SLOTS][NUM_CH];
   logic [BC-1:0]        vo_q   [VIEW_SLOTS][NUM_CH];
   logic [BC-1:0]        vo_d   [VIEW_SLOTS][NUM_CH];
   logic [ADDR_BITS-1:0] ar_q   [NUM_CH];
   logic [ADDR_BITS-1:0] ar_d   [NUM_CH];
   logic [TS_W-1:0]      tile_ptr_q, tile_ptr_d;
   logic [VS_W-1:0]      view_ptr_q, view_ptr_d;

   logic [MODE_BITS-1:0] ch_mode [NUM_CH];
   logic [ADDR_BITS-1:0] ch_addr [NUM_CH];
   logic [BC-1:0]        ch_off  [NUM_CH];
   logic [TOC_WIDTH-1:0] opcode;
   logic                 acc;

   assign opcode   = code_in[NUM_CH*CH_W +: TOC_WIDTH];
   assign in_ready = en & ~flush & rst_n;
   assign acc      = in_valid & in_ready;

   // Per-channel field split of the instruction word and per-channel output slices.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_off[gi]  = code_in[gi*CH_W +: BC];
      assign ch_addr[gi] = code_in[gi*CH_W + BC +: ADDR_BITS];
      assign ch_mode[gi] = code_in[gi*CH_W + BC + ADDR_BITS +: MODE_BITS];
      assign mode[gi*MODE_BITS +: MODE_BITS] = vm_q[view_ptr_q][gi];
      assign offset[gi*BC +: BC]             = vo_q[view_ptr_q][gi];
      assign addr[gi*ADDR_BITS +: ADDR_BITS] = ar_q[gi];
   end

   // Slots are read at the current pointer before this edge's write lands.
   assign code_out    = op_q[tile_ptr_q];
   assign addr_i      = ta_q[tile_ptr_q];
   assign tile_slot   = tile_ptr_q;
   assign frame_start = (tile_ptr_q == '0);
   assign write       = (code_out == WRITE_OP);

   always_comb begin
      op_d       = op_q;
      ta_d       = ta_q;
      vm_d       = vm_q;
      vo_d       = vo_q;
      ar_d       = ar_q;
      tile_ptr_d = tile_ptr_q;
      view_ptr_d = view_ptr_q;
      if (flush) begin
         for (int i = 0; i < TILE_SLOTS; i++) begin
            op_d[i] = NOP_OP;
            ta_d[i] = '0;
         end
         for (int i = 0; i < VIEW_SLOTS; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               vm_d[i][c] = '0;
               vo_d[i][c] = '0;
            end
         end
         for (int c = 0; c < NUM_CH; c++) ar_d[c] = '0;
         tile_ptr_d = '0;
         view_ptr_d = '0;
      end else if (en) begin
         op_d[tile_ptr_q] = acc ? opcode : NOP_OP;
         if (acc) begin
            ta_d[tile_ptr_q] = ch_addr[ADDR_SRC_CH];
            for (int c = 0; c < NUM_CH; c++) begin
               vm_d[view_ptr_q][c] = ch_mode[c];
               vo_d[view_ptr_q][c] = ch_off[c];
               ar_d[c]             = ch_addr[c];
            end
         end
         tile_ptr_d = (tile_ptr_q == TS_W'(TILE_SLOTS - 1)) ? '0 : tile_ptr_q + 1'b1;
         view_ptr_d = (view_ptr_q == VS_W'(VIEW_SLOTS - 1)) ? '0 : view_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TILE_SLOTS; i++) begin
            op_q[i] <= NOP_OP;
            ta_q[i] <= '0;
         end
         for (int i = 0; i < VIEW_SLOTS; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               vm_q[i][c] <= '0;
               vo_q[i][c] <= '0;
            end
         end
         for (int c = 0; c < NUM_CH; c++) ar_q[c] <= '0;
         tile_ptr_q <= '0;
         view_ptr_q <= '0;
      end else begin
         op_q       <= op_d;
         ta_q       <= ta_d;
         vm_q       <= vm_d;
         vo_q       <= vo_d;
         ar_q       <= ar_d;
         tile_ptr_q <= tile_ptr_d;
         view_ptr_q <= view_ptr_d;
      end
   end

endmodule
